// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns RV32I loads and stores into word transactions on a
// single-port memory, using read-modify-write for SB/SH and flagging bad requests.
`timescale 1ns/1ps

module lsu_mem_master #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [2:0]  funct3_q;
    logic        we_q;

    logic        req_legal;
    logic        req_misaligned;
    logic        req_out_of_range;
    logic        req_err;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    // Request classification is done on the live request bus so IDLE can decide in one edge.
    always_comb begin
        req_legal = 1'b0;
        if (req_we) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                        (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
        req_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                           ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_out_of_range = {2'b00, req_addr[31:2]} >= $unsigned(MEM_WORDS);
        req_err          = !req_legal || req_misaligned || req_out_of_range;
    end

    always_comb begin
        lane_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: lane_byte = mem_read_data[7:0];
            2'd1: lane_byte = mem_read_data[15:8];
            2'd2: lane_byte = mem_read_data[23:16];
            2'd3: lane_byte = mem_read_data[31:24];
            default: lane_byte = 8'h00;
        endcase
        lane_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        load_data = 32'h0;
        case (funct3_q)
            3'b000: load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001: load_data = {{16{lane_half[15]}}, lane_half};
            3'b010: load_data = mem_read_data;
            3'b100: load_data = {24'h0, lane_byte};
            3'b101: load_data = {16'h0, lane_half};
            default: load_data = 32'h0;
        endcase
    end

    // Store merge: SW writes the raw data, SB/SH splice their lane into the word read back.
    always_comb begin
        merged_word = word_q;
        case (funct3_q[1:0])
            2'b00: begin
                case (addr_q[1:0])
                    2'd0: merged_word[7:0]   = wdata_q[7:0];
                    2'd1: merged_word[15:8]  = wdata_q[7:0];
                    2'd2: merged_word[23:16] = wdata_q[7:0];
                    2'd3: merged_word[31:24] = wdata_q[7:0];
                    default: merged_word = word_q;
                endcase
            end
            2'b01: begin
                if (addr_q[1]) merged_word[31:16] = wdata_q[15:0];
                else           merged_word[15:0]  = wdata_q[15:0];
            end
            default: merged_word = wdata_q;
        endcase
    end

    assign req_ready        = (state == ST_IDLE);
    assign resp_valid       = (state == ST_RESP);
    assign mem_write_enable = (state == ST_WRITE);
    assign mem_write_data   = (state == ST_WRITE) ? merged_word : 32'h0;
    assign mem_address      = {addr_q[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            word_q     <= 32'h0;
            funct3_q   <= 3'b000;
            we_q       <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        if (req_err) begin
                            resp_rdata <= 32'h0;
                            resp_err   <= 1'b1;
                            state      <= ST_RESP;
                        end else if (req_we && (req_funct3 == 3'b010)) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    word_q <= mem_read_data;
                    if (we_q) begin
                        state <= ST_WRITE;
                    end else begin
                        resp_rdata <= load_data;
                        resp_err   <= 1'b0;
                        state      <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: directed spec cases, held-valid back-to-back traffic,
// mid-RMW reset and a randomized sweep checked against a byte-level memory model.
`timescale 1ns/1ps

module tb_lsu_mem_master;

    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    logic [31:0] mem     [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    int          compared   = 0;
    int          mismatched = 0;
    int          wr_count   = 0;
    logic [31:0] wr_addr_last = 32'h0;
    logic [31:0] wr_data_last = 32'h0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    lsu_mem_master #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Attached memory: combinational read, posedge write, plus a write monitor.
    assign mem_read_data = mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_address[9:2]] <= mem_write_data;
            wr_count     <= wr_count + 1;
            wr_addr_last <= mem_address;
            wr_data_last <= mem_write_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-lane arithmetic on a word array, updated on successful stores.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err,
                                  output int lat, output int nwr, output logic [31:0] wword);
        int          bytes;
        int          off;
        int unsigned idx;
        bit          legal;
        logic [31:0] mask;
        logic [31:0] v;
        bytes = 1 << f3[1:0];
        off   = int'(a[1:0]);
        idx   = a >> 2;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        rd = 32'h0; err = 1'b0; lat = 0; nwr = 0; wword = 32'h0;
        if (!legal || (off % bytes) != 0 || idx >= MEM_WORDS) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * bytes)) - 32'h1);
        if (we) begin
            wword = (ref_mem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            ref_mem[idx] = wword;
            lat = (bytes == 4) ? 2 : 3;
            nwr = 1;
        end else begin
            v = (ref_mem[idx] >> (8 * off)) & mask;
            if (!f3[2] && bytes < 4 && ((v >> (8 * bytes - 1)) & 32'h1) == 32'h1) v = v | ~mask;
            rd  = v;
            lat = 2;
        end
    endfunction

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        logic [31:0] exp_rd;
        logic [31:0] exp_ww;
        logic        exp_err;
        int          exp_lat;
        int          exp_nwr;
        int          n;
        int          k;
        int          wr0;
        logic        got;
        logic [31:0] rd;
        logic        er;
        model(we, f3, addr, wdata, exp_rd, exp_err, exp_lat, exp_nwr, exp_ww);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) checkOutput("ready_timeout", 32'(req_ready), 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        wr0 = wr_count;
        @(posedge clk);
        got = 1'b0; k = 0; rd = 32'h0; er = 1'b0;
        // While busy, the request bus carries junk that must be ignored.
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                er  = resp_err;
                req_valid = 1'b0;
            end else begin
                req_valid  = 1'b1;
                req_we     = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
        end
        if (!got) req_valid = 1'b0;
        checkOutput("resp_seen", 32'(got), 32'h1);
        checkOutput("latency", 32'(k), 32'(exp_lat));
        checkOutput("rdata", rd, exp_rd);
        checkOutput("err", 32'(er), 32'(exp_err));
        checkOutput("write_count", 32'(wr_count - wr0), 32'(exp_nwr));
        if (exp_nwr != 0) begin
            checkOutput("write_data", wr_data_last, exp_ww);
            checkOutput("write_addr", wr_addr_last, {addr[31:2], 2'b00});
            checkOutput("mem_word", mem[addr[9:2]], ref_mem[addr[9:2]]);
        end
        last_rdata = rd;
        last_err   = er;
        last_lat   = k;
    endtask

    initial begin
        logic [31:0] exp_rd;
        logic [31:0] exp_ww;
        logic        exp_err;
        int          exp_lat;
        int          exp_nwr;
        int          resps;
        int          wr0;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'hDEADBEEF; ref_mem[0] = 32'hDEADBEEF;
        mem[1] = 32'h12345678; ref_mem[1] = 32'h12345678;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready), 32'h1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("rst_rdata", resp_rdata, 32'h0);
        checkOutput("rst_err", 32'(resp_err), 32'h0);
        checkOutput("rst_mwe", 32'(mem_write_enable), 32'h0);
        checkOutput("rst_maddr", mem_address, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed loads");
        applyStimulus(1'b0, 3'b000, 32'h1, 32'h0);
        checkOutput("lb_value", last_rdata, 32'hFFFFFFBE);
        checkOutput("lb_latency", 32'(last_lat), 32'd2);
        applyStimulus(1'b0, 3'b100, 32'h3, 32'h0);
        checkOutput("lbu_value", last_rdata, 32'h000000DE);
        applyStimulus(1'b0, 3'b101, 32'h2, 32'h0);
        checkOutput("lhu_value", last_rdata, 32'h0000DEAD);
        applyStimulus(1'b0, 3'b001, 32'h0, 32'h0);
        checkOutput("lh_value", last_rdata, 32'hFFFFBEEF);

        $display("[TB] directed stores");
        applyStimulus(1'b1, 3'b000, 32'h5, 32'hFFFFFFAA);
        checkOutput("sb_latency", 32'(last_lat), 32'd3);
        checkOutput("sb_written", wr_data_last, 32'h1234AA78);
        applyStimulus(1'b0, 3'b010, 32'h4, 32'h0);
        checkOutput("sb_readback", last_rdata, 32'h1234AA78);
        applyStimulus(1'b1, 3'b010, 32'h50, 32'hCAFEF00D);
        checkOutput("sw_latency", 32'(last_lat), 32'd2);
        applyStimulus(1'b0, 3'b010, 32'h50, 32'h0);
        checkOutput("sw_readback", last_rdata, 32'hCAFEF00D);

        $display("[TB] directed errors");
        applyStimulus(1'b0, 3'b010, 32'h2, 32'h0);
        checkOutput("lw_misaligned_err", 32'(last_err), 32'h1);
        applyStimulus(1'b1, 3'b001, 32'h1, 32'h12345678);
        checkOutput("sh_misaligned_err", 32'(last_err), 32'h1);
        checkOutput("sh_misaligned_lat", 32'(last_lat), 32'd1);
        applyStimulus(1'b0, 3'b011, 32'h0, 32'h0);
        checkOutput("illegal_f3_err", 32'(last_err), 32'h1);
        applyStimulus(1'b0, 3'b010, 32'h400, 32'h0);
        checkOutput("out_of_range_err", 32'(last_err), 32'h1);
        checkOutput("mem_word0_intact", mem[0], 32'hDEADBEEF);

        // Holding LW valid for 12 edges: accepts land every third edge, giving 4 responses.
        $display("[TB] back-to-back held valid");
        model(1'b0, 3'b010, 32'h50, 32'h0, exp_rd, exp_err, exp_lat, exp_nwr, exp_ww);
        while (!req_ready) @(negedge clk);
        wr0 = wr_count;
        resps = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h50; req_wdata = 32'h0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                resps++;
                checkOutput("b2b_rdata", resp_rdata, exp_rd);
            end
        end
        req_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) resps++;
        end
        checkOutput("b2b_resp_count", 32'(resps), 32'd4);
        checkOutput("b2b_no_writes", 32'(wr_count - wr0), 32'h0);

        $display("[TB] reset during SH read");
        while (!req_ready) @(negedge clk);
        wr0 = wr_count;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'hC; req_wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_mwe", 32'(mem_write_enable), 32'h0);
        checkOutput("abort_ready", 32'(req_ready), 32'h1);
        checkOutput("abort_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("abort_rdata", resp_rdata, 32'h0);
        checkOutput("abort_err", 32'(resp_err), 32'h0);
        checkOutput("abort_maddr", mem_address, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_no_write", 32'(wr_count - wr0), 32'h0);
        checkOutput("abort_mem_intact", mem[3], ref_mem[3]);

        $display("[TB] randomized sweep");
        for (int i = 0; i < 250; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(7, 0));
            if (we && $urandom_range(3, 0) != 0) f3 = 3'($urandom_range(2, 0));
            addr = {22'h0, 8'($urandom_range(255, 0)), 2'($urandom)};
            if ($urandom_range(9, 0) == 0) addr = {20'h0, 10'($urandom_range(300, 256)), 2'($urandom)};
            if ($urandom_range(29, 0) == 0) addr = $urandom;
            applyStimulus(we, f3, addr, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
